// File: rtl/mem_copy_engine.sv
// rtl/mem_copy_engine.sv - word-granular memory copy engine, initiator side of cpu_req/cpu_resp
module mem_copy_engine #(
  parameter int CPU_WIDTH      = 32,
  parameter int WORD_ADDR_BITS = 30,
  parameter int LEN_BITS       = 16,
  parameter int TIMEOUT        = 16
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      start,
  input  logic [WORD_ADDR_BITS-1:0] src_addr,
  input  logic [WORD_ADDR_BITS-1:0] dst_addr,
  input  logic [LEN_BITS-1:0]       len,
  output logic                      busy,
  output logic                      done,
  output logic                      error,
  output logic [LEN_BITS-1:0]       words_done,
  output logic                      mem_req_val,
  input  logic                      mem_req_rdy,
  output logic [WORD_ADDR_BITS-1:0] mem_req_addr,
  output logic [CPU_WIDTH-1:0]      mem_req_data,
  output logic [3:0]                mem_req_write,
  input  logic                      mem_resp_val,
  input  logic [CPU_WIDTH-1:0]      mem_resp_data
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RD_REQ  = 3'd1;
  localparam logic [2:0] S_RD_WAIT = 3'd2;
  localparam logic [2:0] S_WR_REQ  = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  localparam int TW = $clog2(TIMEOUT) + 1;
  // Abort on the wait cycle whose increment would bring the counter to TIMEOUT-1
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 2);

  logic [2:0]                r_state;
  logic [WORD_ADDR_BITS-1:0] r_src;
  logic [WORD_ADDR_BITS-1:0] r_dst;
  logic [LEN_BITS-1:0]       r_len;
  logic [LEN_BITS-1:0]       r_idx;
  logic [CPU_WIDTH-1:0]      r_buf;
  logic [TW-1:0]             r_to_cnt;
  logic                      r_error;

  logic [LEN_BITS-1:0]       w_idx_inc;
  logic [WORD_ADDR_BITS-1:0] w_rd_addr;
  logic [WORD_ADDR_BITS-1:0] w_wr_addr;

  assign w_idx_inc = r_idx + 1'b1;
  assign w_rd_addr = r_src + WORD_ADDR_BITS'(r_idx);
  assign w_wr_addr = r_dst + WORD_ADDR_BITS'(r_idx);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_error  <= 1'b0;
      r_idx    <= '0;
      r_src    <= '0;
      r_dst    <= '0;
      r_len    <= '0;
      r_buf    <= '0;
      r_to_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_error <= 1'b0;
            r_idx   <= '0;
            if (len != '0) begin
              r_src   <= src_addr;
              r_dst   <= dst_addr;
              r_len   <= len;
              r_state <= S_RD_REQ;
            end else begin
              r_state <= S_DONE;
            end
          end
        end
        S_RD_REQ: begin
          if (mem_req_rdy) begin
            r_to_cnt <= '0;
            r_state  <= S_RD_WAIT;
          end
        end
        S_RD_WAIT: begin
          if (mem_resp_val) begin
            r_buf   <= mem_resp_data;
            r_state <= S_WR_REQ;
          end else if (r_to_cnt == TO_LAST) begin
            r_error <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
        end
        S_WR_REQ: begin
          if (mem_req_rdy) begin
            r_idx   <= w_idx_inc;
            r_state <= (w_idx_inc == r_len) ? S_DONE : S_RD_REQ;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Outputs depend only on registered state, never on rdy/resp inputs
  assign busy          = (r_state != S_IDLE);
  assign done          = (r_state == S_DONE);
  assign error         = r_error;
  assign words_done    = r_idx;
  assign mem_req_val   = (r_state == S_RD_REQ) || (r_state == S_WR_REQ);
  assign mem_req_addr  = (r_state == S_WR_REQ) ? w_wr_addr : w_rd_addr;
  assign mem_req_data  = r_buf;
  assign mem_req_write = (r_state == S_WR_REQ) ? 4'hF : 4'h0;

endmodule

// File: tb/tb_mem_copy_engine.sv
// tb/tb_mem_copy_engine.sv - directed self-checking bench for mem_copy_engine
module tb_mem_copy_engine;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [29:0] src_addr;
  logic [29:0] dst_addr;
  logic [15:0] len;
  logic        busy;
  logic        done;
  logic        error;
  logic [15:0] words_done;
  logic        mem_req_val;
  logic        mem_req_rdy;
  logic [29:0] mem_req_addr;
  logic [31:0] mem_req_data;
  logic [3:0]  mem_req_write;
  logic        mem_resp_val;
  logic [31:0] mem_resp_data;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [logic [29:0]];
  logic [29:0] rd_log [$];
  logic [29:0] wr_log [$];
  int          rd_cnt;
  int          wr_cnt;
  bit          resp_en = 1'b1;

  int          val_cnt;
  int          busy_cnt;
  int          stab_viol;

  always #5 clk = ~clk;

  mem_copy_engine dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .src_addr     (src_addr),
    .dst_addr     (dst_addr),
    .len          (len),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .words_done   (words_done),
    .mem_req_val  (mem_req_val),
    .mem_req_rdy  (mem_req_rdy),
    .mem_req_addr (mem_req_addr),
    .mem_req_data (mem_req_data),
    .mem_req_write(mem_req_write),
    .mem_resp_val (mem_resp_val),
    .mem_resp_data(mem_resp_data)
  );

  function automatic logic [31:0] rd_mem(input logic [29:0] a);
    if (mem.exists(a)) return mem[a];
    return 32'h0;
  endfunction

  // Memory responder: reads return one cycle after acceptance
  always @(posedge clk) begin
    if (!reset_n) begin
      mem_resp_val <= 1'b0;
    end else begin
      mem_resp_val <= 1'b0;
      if (mem_req_val && mem_req_rdy) begin
        if (mem_req_write == 4'hF) begin
          mem[mem_req_addr] = mem_req_data;
          wr_log.push_back(mem_req_addr);
          wr_cnt++;
        end else begin
          rd_log.push_back(mem_req_addr);
          rd_cnt++;
          if (resp_en) begin
            mem_resp_val  <= 1'b1;
            mem_resp_data <= rd_mem(mem_req_addr);
          end
        end
      end
    end
  end

  // Pulses start, then follows the copy cycle by cycle (cycle 1 = first after acceptance)
  task automatic start_and_wait(input logic [29:0] s, input logic [29:0] d, input logic [15:0] l,
                                input bit stall, input int max_cyc, output int done_cyc);
    logic        hold;
    logic [29:0] h_addr;
    logic [31:0] h_data;
    logic [3:0]  h_write;
    hold = 1'b0;
    h_addr = '0;
    h_data = '0;
    h_write = '0;
    @(negedge clk);
    rd_cnt = 0; wr_cnt = 0; rd_log.delete(); wr_log.delete();
    val_cnt = 0; busy_cnt = 0; stab_viol = 0;
    src_addr = s; dst_addr = d; len = l; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    done_cyc = -1;
    for (int c = 1; c <= max_cyc; c++) begin
      if (mem_req_val) val_cnt++;
      if (busy) busy_cnt++;
      if (hold && (!mem_req_val || mem_req_addr != h_addr || mem_req_data != h_data ||
                   mem_req_write != h_write)) stab_viol++;
      if (done) begin
        done_cyc = c;
        break;
      end
      mem_req_rdy = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      hold = mem_req_val && !mem_req_rdy;
      h_addr = mem_req_addr; h_data = mem_req_data; h_write = mem_req_write;
      @(negedge clk);
    end
    mem_req_rdy = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, error, mem_req_val} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 0000", {busy, done, error, mem_req_val});
    end
    checks++;
    if (mem_req_write !== 4'h0 || words_done !== 16'd0) begin
      errors++;
      $display("FAIL reset_write_words: got %h/%0d expected 0/0", mem_req_write, words_done);
    end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic_copy();
    int dc;
    for (int i = 0; i < 4; i++) mem[30'h100 + 30'(i)] = 32'hA0 + 32'(i);
    start_and_wait(30'h100, 30'h200, 16'd4, 1'b0, 40, dc);
    checks++;
    if (dc !== 13) begin
      errors++;
      $display("FAIL basic_done_cycle: got %0d expected 13", dc);
    end
    checks++;
    if (words_done !== 16'd4 || error !== 1'b0) begin
      errors++;
      $display("FAIL basic_status: got words=%0d err=%b expected 4/0", words_done, error);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rd_mem(30'h200 + 30'(i)) !== 32'hA0 + 32'(i)) begin
        errors++;
        $display("FAIL basic_data[%0d]: got %h expected %h", i, rd_mem(30'h200 + 30'(i)), 32'hA0 + 32'(i));
      end
    end
    checks++;
    if (rd_cnt !== 4 || wr_cnt !== 4) begin
      errors++;
      $display("FAIL basic_counts: got rd=%0d wr=%0d expected 4/4", rd_cnt, wr_cnt);
    end
  endtask

  task automatic test_zero_len();
    int dc;
    start_and_wait(30'h100, 30'h280, 16'd0, 1'b0, 10, dc);
    checks++;
    if (dc !== 1) begin
      errors++;
      $display("FAIL zero_done_cycle: got %0d expected 1", dc);
    end
    checks++;
    if (val_cnt !== 0 || rd_cnt !== 0 || wr_cnt !== 0) begin
      errors++;
      $display("FAIL zero_traffic: got val=%0d rd=%0d wr=%0d expected 0", val_cnt, rd_cnt, wr_cnt);
    end
    checks++;
    if (words_done !== 16'd0) begin
      errors++;
      $display("FAIL zero_words: got %0d expected 0", words_done);
    end
    @(negedge clk);
    checks++;
    if (busy_cnt !== 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL zero_busy: got cycles=%0d after=%b expected 1/0", busy_cnt, busy);
    end
  endtask

  task automatic test_stalls();
    int dc;
    int bad;
    for (int i = 0; i < 8; i++) mem[30'h300 + 30'(i)] = 32'h1234_0000 + 32'(i) * 32'h111;
    start_and_wait(30'h300, 30'h400, 16'd8, 1'b1, 300, dc);
    checks++;
    if (dc < 25) begin
      errors++;
      $display("FAIL stall_done: got cycle %0d expected >= 25", dc);
    end
    checks++;
    if (stab_viol !== 0) begin
      errors++;
      $display("FAIL stall_hold: got %0d changes expected 0", stab_viol);
    end
    checks++;
    if (rd_cnt !== 8 || wr_cnt !== 8) begin
      errors++;
      $display("FAIL stall_counts: got rd=%0d wr=%0d expected 8/8", rd_cnt, wr_cnt);
    end
    bad = 0;
    for (int i = 0; i < 8; i++)
      if (rd_mem(30'h400 + 30'(i)) !== 32'h1234_0000 + 32'(i) * 32'h111) bad++;
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL stall_data: got %0d wrong words expected 0", bad);
    end
    checks++;
    if (words_done !== 16'd8) begin
      errors++;
      $display("FAIL stall_words: got %0d expected 8", words_done);
    end
  endtask

  task automatic test_wrap();
    int dc;
    mem[30'h3FFF_FFFF] = 32'h5555_AAAA;
    mem[30'h0] = 32'h0BAD_F00D;
    start_and_wait(30'h3FFF_FFFF, 30'h10, 16'd2, 1'b0, 40, dc);
    checks++;
    if (rd_log.size() !== 2 || wr_log.size() !== 2) begin
      errors++;
      $display("FAIL wrap_sizes: got rd=%0d wr=%0d expected 2/2", rd_log.size(), wr_log.size());
    end else begin
      checks++;
      if (rd_log[0] !== 30'h3FFF_FFFF || rd_log[1] !== 30'h0) begin
        errors++;
        $display("FAIL wrap_rd_addr: got %h,%h expected 3fffffff,0", rd_log[0], rd_log[1]);
      end
      checks++;
      if (wr_log[0] !== 30'h10 || wr_log[1] !== 30'h11) begin
        errors++;
        $display("FAIL wrap_wr_addr: got %h,%h expected 10,11", wr_log[0], wr_log[1]);
      end
    end
    checks++;
    if (rd_mem(30'h10) !== 32'h5555_AAAA || rd_mem(30'h11) !== 32'h0BAD_F00D) begin
      errors++;
      $display("FAIL wrap_data: got %h,%h expected 5555aaaa,0badf00d", rd_mem(30'h10), rd_mem(30'h11));
    end
  endtask

  task automatic test_timeout();
    int dc;
    resp_en = 1'b0;
    start_and_wait(30'h100, 30'h500, 16'd3, 1'b0, 60, dc);
    checks++;
    if (dc !== 17) begin
      errors++;
      $display("FAIL timeout_done_cycle: got %0d expected 17", dc);
    end
    checks++;
    if (error !== 1'b1 || words_done !== 16'd0 || wr_cnt !== 0 || rd_cnt !== 1) begin
      errors++;
      $display("FAIL timeout_status: got err=%b words=%0d rd=%0d wr=%0d expected 1/0/1/0",
               error, words_done, rd_cnt, wr_cnt);
    end
    @(negedge clk);
    checks++;
    if (error !== 1'b1) begin
      errors++;
      $display("FAIL timeout_sticky: got %b expected 1", error);
    end
    resp_en = 1'b1;
    start_and_wait(30'h100, 30'h500, 16'd1, 1'b0, 40, dc);
    checks++;
    if (dc !== 4 || error !== 1'b0 || rd_mem(30'h500) !== 32'hA0) begin
      errors++;
      $display("FAIL timeout_recover: got cyc=%0d err=%b data=%h expected 4/0/a0", dc, error, rd_mem(30'h500));
    end
  endtask

  task automatic test_reset_mid_copy();
    int dc;
    int done_seen;
    @(negedge clk);
    src_addr = 30'h100; dst_addr = 30'h600; len = 16'd4; start = 1'b1;
    @(negedge clk);
    src_addr = 30'h900; dst_addr = 30'h900; len = 16'd1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_req_write !== 4'hF || mem_req_addr !== 30'h600) begin
      errors++;
      $display("FAIL busy_start_ignored: got wr=%h addr=%h expected f/600", mem_req_write, mem_req_addr);
    end
    reset_n = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_req_val !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_abort: got val=%b busy=%b expected 0/0", mem_req_val, busy);
    end
    reset_n = 1'b1;
    done_seen = 0;
    for (int c = 0; c < 10; c++) begin
      if (done) done_seen++;
      @(negedge clk);
    end
    checks++;
    if (done_seen !== 0) begin
      errors++;
      $display("FAIL reset_no_done: got %0d pulses expected 0", done_seen);
    end
    start_and_wait(30'h100, 30'h640, 16'd4, 1'b0, 40, dc);
    start = 1'b1; len = 16'd0;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (dc !== 13 || busy !== 1'b0 || words_done !== 16'd4) begin
      errors++;
      $display("FAIL after_reset_copy: got cyc=%0d busy=%b words=%0d expected 13/0/4", dc, busy, words_done);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rd_mem(30'h640 + 30'(i)) !== 32'hA0 + 32'(i)) begin
        errors++;
        $display("FAIL after_reset_data[%0d]: got %h expected %h", i, rd_mem(30'h640 + 30'(i)), 32'hA0 + 32'(i));
      end
    end
  endtask

  initial begin
    reset_n = 1'b0;
    start = 1'b0;
    src_addr = '0;
    dst_addr = '0;
    len = '0;
    mem_req_rdy = 1'b1;
    test_reset();
    test_basic_copy();
    test_zero_len();
    test_stalls();
    test_wrap();
    test_timeout();
    test_reset_mid_copy();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
